// File: rtl/strip_receiver.sv
`default_nettype none
// ============================================================================
// Module      : strip_receiver
// Description : Capture side of the single-wire LED strip protocol. The strip
//               line is synchronised and each high pulse is classified by
//               width as a 0 or 1. Bits are assembled MSB-first into bytes,
//               and each byte is written to a byte-wide memory at consecutive
//               addresses. A long low ends the frame. A line held high too
//               long is reported as an error and the frame is discarded.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               strip_in        - asynchronous strip data line
//               mem_addr/data/we- byte write port (one-cycle strobe)
//               frame_done      - one-cycle pulse at frame end
//               frame_bytes     - bytes written in the frame (valid with done)
//               frame_error     - partial byte at frame end, or stuck-high line
//               frame_overflow  - frame carried more than CAPACITY bytes
// Revision    : 1.0 - initial release
// ============================================================================
module strip_receiver #(
    parameter int INPUT_CLOCK_FREQ_MHZ = 50,
    parameter int MAX_LEDS             = 3,
    parameter int NUM_CHANNELS         = 3,
    parameter int ADDRESS_WIDTH        = 13,
    parameter int BASE_ADDRESS         = 0,
    parameter int MIN_HIGH_NS          = 100,
    parameter int ONE_THRESHOLD_NS     = 700,
    parameter int MAX_HIGH_NS          = 5000,
    parameter int RESET_DETECT_NS      = 50000
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      strip_in,
    output logic [ADDRESS_WIDTH-1:0]                  mem_addr,
    output logic [7:0]                                mem_data,
    output logic                                      mem_we,
    output logic                                      frame_done,
    output logic [$clog2(MAX_LEDS*NUM_CHANNELS):0]    frame_bytes,
    output logic                                      frame_error,
    output logic                                      frame_overflow
);

    localparam int CAPACITY             = MAX_LEDS * NUM_CHANNELS;
    localparam int FB_W                 = $clog2(CAPACITY) + 1;
    localparam int MIN_HIGH_CYCLES      = MIN_HIGH_NS      * INPUT_CLOCK_FREQ_MHZ / 1000;
    localparam int ONE_THRESHOLD_CYCLES = ONE_THRESHOLD_NS * INPUT_CLOCK_FREQ_MHZ / 1000;
    localparam int MAX_HIGH_CYCLES      = MAX_HIGH_NS      * INPUT_CLOCK_FREQ_MHZ / 1000;
    localparam int RESET_CYCLES         = RESET_DETECT_NS  * INPUT_CLOCK_FREQ_MHZ / 1000;
    localparam int CNT_MAX = (RESET_CYCLES > MAX_HIGH_CYCLES) ? RESET_CYCLES : MAX_HIGH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]         MIN_CNT   = CNT_W'(MIN_HIGH_CYCLES);
    localparam logic [CNT_W-1:0]         ONE_CNT   = CNT_W'(ONE_THRESHOLD_CYCLES);
    localparam logic [CNT_W-1:0]         MAX_CNT   = CNT_W'(MAX_HIGH_CYCLES);
    localparam logic [CNT_W-1:0]         RESET_CNT = CNT_W'(RESET_CYCLES);
    localparam logic [FB_W-1:0]          CAP       = FB_W'(CAPACITY);
    localparam logic [ADDRESS_WIDTH-1:0] BASE      = ADDRESS_WIDTH'(BASE_ADDRESS);

    localparam logic [1:0] S_WAIT_RESET = 2'd0;
    localparam logic [1:0] S_IDLE       = 2'd1;
    localparam logic [1:0] S_HIGH       = 2'd2;
    localparam logic [1:0] S_LOW        = 2'd3;

    logic                     sync1_q, s_q, s_prev_q;
    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         low_count_q, low_count_d;
    logic [CNT_W-1:0]         high_count_q, high_count_d;
    logic [6:0]               shift_q, shift_d;      // bits already received of the current byte
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [FB_W-1:0]          index_q, index_d;
    logic                     ovf_q, ovf_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]               mem_data_q, mem_data_d;
    logic                     mem_we_q, mem_we_d;
    logic                     frame_done_q, frame_done_d;
    logic [FB_W-1:0]          frame_bytes_q, frame_bytes_d;
    logic                     frame_error_q, frame_error_d;
    logic                     frame_overflow_q, frame_overflow_d;

    logic             s_rise, s_fall, bit_val;
    logic [CNT_W-1:0] low_inc, high_inc;
    logic [7:0]       byte_val;

    assign s_rise   = s_q & ~s_prev_q;
    assign s_fall   = ~s_q & s_prev_q;
    assign low_inc  = low_count_q + CNT_W'(1);
    assign high_inc = high_count_q + CNT_W'(1);
    assign bit_val  = (high_count_q >= ONE_CNT);
    assign byte_val = {shift_q, bit_val};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q          <= 1'b0;
            s_q              <= 1'b0;
            s_prev_q         <= 1'b0;
            state_q          <= S_WAIT_RESET;
            low_count_q      <= '0;
            high_count_q     <= '0;
            shift_q          <= '0;
            bit_cnt_q        <= '0;
            index_q          <= '0;
            ovf_q            <= 1'b0;
            mem_addr_q       <= BASE;
            mem_data_q       <= '0;
            mem_we_q         <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_bytes_q    <= '0;
            frame_error_q    <= 1'b0;
            frame_overflow_q <= 1'b0;
        end else begin
            sync1_q          <= strip_in;
            s_q              <= sync1_q;
            s_prev_q         <= s_q;
            state_q          <= state_d;
            low_count_q      <= low_count_d;
            high_count_q     <= high_count_d;
            shift_q          <= shift_d;
            bit_cnt_q        <= bit_cnt_d;
            index_q          <= index_d;
            ovf_q            <= ovf_d;
            mem_addr_q       <= mem_addr_d;
            mem_data_q       <= mem_data_d;
            mem_we_q         <= mem_we_d;
            frame_done_q     <= frame_done_d;
            frame_bytes_q    <= frame_bytes_d;
            frame_error_q    <= frame_error_d;
            frame_overflow_q <= frame_overflow_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_RESET: if (!s_q && low_inc >= RESET_CNT) state_d = S_IDLE;
            S_IDLE:       if (s_rise) state_d = S_HIGH;
            S_HIGH: begin
                if (s_fall)                     state_d = S_LOW;
                else if (high_inc >= MAX_CNT)   state_d = S_WAIT_RESET;
            end
            S_LOW: begin
                if (s_rise)                     state_d = S_HIGH;
                else if (low_inc >= RESET_CNT)  state_d = S_IDLE;
            end
            default:                            state_d = S_WAIT_RESET;
        endcase
    end

    // Counters, bit assembly and registered output strobes
    always_comb begin
        low_count_d      = low_count_q;
        high_count_d     = high_count_q;
        shift_d          = shift_q;
        bit_cnt_d        = bit_cnt_q;
        index_d          = index_q;
        ovf_d            = ovf_q;
        mem_addr_d       = mem_addr_q;
        mem_data_d       = mem_data_q;
        mem_we_d         = 1'b0;
        frame_done_d     = 1'b0;
        frame_bytes_d    = frame_bytes_q;
        frame_error_d    = 1'b0;
        frame_overflow_d = 1'b0;
        case (state_q)
            S_WAIT_RESET: begin
                // Any frame content seen here is discarded
                low_count_d = s_q ? '0 : low_inc;
                shift_d     = '0;
                bit_cnt_d   = '0;
                index_d     = '0;
                ovf_d       = 1'b0;
            end
            S_IDLE: begin
                shift_d   = '0;
                bit_cnt_d = '0;
                index_d   = '0;
                ovf_d     = 1'b0;
                if (s_rise) high_count_d = CNT_W'(1);
            end
            S_HIGH: begin
                if (s_fall) begin
                    low_count_d = CNT_W'(1);
                    // Pulses shorter than the glitch floor leave the bit state untouched
                    if (high_count_q >= MIN_CNT) begin
                        shift_d   = byte_val[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (index_q < CAP) begin
                                mem_we_d   = 1'b1;
                                mem_data_d = byte_val;
                                mem_addr_d = BASE + ADDRESS_WIDTH'(index_q);
                                index_d    = index_q + FB_W'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    high_count_d = high_inc;
                    if (high_inc >= MAX_CNT) begin
                        frame_error_d = 1'b1;
                        low_count_d   = '0;
                    end
                end
            end
            S_LOW: begin
                if (s_rise) begin
                    high_count_d = CNT_W'(1);
                end else begin
                    low_count_d = low_inc;
                    if (low_inc >= RESET_CNT) begin
                        frame_done_d     = 1'b1;
                        frame_bytes_d    = index_q;   // index saturates at CAPACITY
                        frame_error_d    = (bit_cnt_q != 3'd0);
                        frame_overflow_d = ovf_q;
                        shift_d          = '0;
                        bit_cnt_d        = '0;
                        index_d          = '0;
                        ovf_d            = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign mem_addr       = mem_addr_q;
    assign mem_data       = mem_data_q;
    assign mem_we         = mem_we_q;
    assign frame_done     = frame_done_q;
    assign frame_bytes    = frame_bytes_q;
    assign frame_error    = frame_error_q;
    assign frame_overflow = frame_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_strip_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_strip_receiver
// Description : Scoreboard bench for strip_receiver. Stimulus pushes the
//               expected memory writes and frame events into a queue; a
//               monitor pops and compares whenever the DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strip_receiver;

    localparam int K_WR    = 0;
    localparam int K_DONE  = 1;
    localparam int K_STUCK = 2;

    typedef struct {
        int         kind;
        logic [12:0] addr;
        logic [7:0]  data;
        logic [4:0]  bytes;
        logic        err;
        logic        ovf;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strip_in = 1'b0;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        frame_done;
    logic [4:0]  frame_bytes;
    logic        frame_error;
    logic        frame_overflow;

    ev_t exp_q[$];
    int  nvec  = 0;
    int  nfail = 0;

    strip_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .strip_in       (strip_in),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_we         (mem_we),
        .frame_done     (frame_done),
        .frame_bytes    (frame_bytes),
        .frame_error    (frame_error),
        .frame_overflow (frame_overflow)
    );

    always #5 clk = ~clk;

    function automatic void push_wr(input logic [12:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = K_WR; e.addr = a; e.data = d; e.bytes = '0; e.err = 1'b0; e.ovf = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_done(input logic [4:0] b, input logic er, input logic ov);
        ev_t e;
        e.kind = K_DONE; e.addr = '0; e.data = '0; e.bytes = b; e.err = er; e.ovf = ov;
        exp_q.push_back(e);
    endfunction

    function automatic void push_stuck();
        ev_t e;
        e.kind = K_STUCK; e.addr = '0; e.data = '0; e.bytes = '0; e.err = 1'b1; e.ovf = 1'b0;
        exp_q.push_back(e);
    endfunction

    // Monitor: compares every strobe the DUT presents against the scoreboard
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_we && frame_done) begin
                    nvec++; nfail++;
                    $display("FAIL we_done_overlap: mem_we and frame_done both high at %0t", $time);
                end
                if (mem_we) begin
                    nvec++;
                    if (exp_q.size() == 0) begin
                        nfail++;
                        $display("FAIL unexpected_write: got addr=%0d data=%02h, no write expected", mem_addr, mem_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != K_WR || mem_addr !== e.addr || mem_data !== e.data) begin
                            nfail++;
                            $display("FAIL write: got addr=%0d data=%02h, expected kind=%0d addr=%0d data=%02h",
                                     mem_addr, mem_data, e.kind, e.addr, e.data);
                        end
                    end
                end
                if (frame_done) begin
                    nvec++;
                    if (exp_q.size() == 0) begin
                        nfail++;
                        $display("FAIL unexpected_done: got bytes=%0d err=%b ovf=%b, no frame end expected",
                                 frame_bytes, frame_error, frame_overflow);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != K_DONE || frame_bytes !== e.bytes || frame_error !== e.err ||
                            frame_overflow !== e.ovf) begin
                            nfail++;
                            $display("FAIL frame_done: got bytes=%0d err=%b ovf=%b, expected kind=%0d bytes=%0d err=%b ovf=%b",
                                     frame_bytes, frame_error, frame_overflow, e.kind, e.bytes, e.err, e.ovf);
                        end
                    end
                end else if (frame_error) begin
                    nvec++;
                    if (exp_q.size() == 0) begin
                        nfail++;
                        $display("FAIL unexpected_error: frame_error pulsed with no event expected");
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != K_STUCK || frame_overflow !== 1'b0) begin
                            nfail++;
                            $display("FAIL stuck_error: got error-only pulse ovf=%b, expected kind=%0d", frame_overflow, e.kind);
                        end
                    end
                end else if (frame_overflow) begin
                    nvec++; nfail++;
                    $display("FAIL stray_overflow: frame_overflow=1 without frame_done");
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        strip_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(50, 20);
        else   pulse(20, 50);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Boundary widths (34 -> 0, 35 -> 1) with a 3-cycle glitch before every bit
    task automatic send_byte_edge(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            pulse(3, 10);
            if (b[i]) pulse(35, 35);
            else      pulse(34, 36);
        end
    endtask

    task automatic check_reset(input string name);
        nvec++;
        if (mem_addr !== 13'd0 || mem_data !== 8'd0 || mem_we !== 1'b0 || frame_done !== 1'b0 ||
            frame_bytes !== 5'd0 || frame_error !== 1'b0 || frame_overflow !== 1'b0) begin
            nfail++;
            $display("FAIL %s: got addr=%0d data=%02h we=%b done=%b bytes=%0d err=%b ovf=%b, expected all zero",
                     name, mem_addr, mem_data, mem_we, frame_done, frame_bytes, frame_error, frame_overflow);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        nvec++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL %s: %0d expected events never seen, expected 0 pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [7:0] t1 [9];
        t1 = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

        // Reset values
        rst = 1'b1;
        strip_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        rst = 1'b0;

        // Bits before any reset band are ignored; the band then arms capture
        send_byte(8'h55);
        drive(1'b0, 2600);

        // Nominal 9-byte frame
        for (int i = 0; i < 9; i++) push_wr(13'(i), t1[i]);
        push_done(5'd9, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) send_byte(t1[i]);
        drive(1'b0, 2600);
        wait_drain("frame_nominal");

        // Overflow: 12 bytes, only 9 written
        for (int i = 0; i < 9; i++) push_wr(13'(i), 8'(8'h10 + i));
        push_done(5'd9, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i));
        drive(1'b0, 2600);
        wait_drain("frame_overflow");

        // Partial byte at frame end
        push_wr(13'd0, 8'h3C);
        push_wr(13'd1, 8'hC3);
        push_done(5'd2, 1'b1, 1'b0);
        send_byte(8'h3C);
        send_byte(8'hC3);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        drive(1'b0, 2600);
        wait_drain("frame_partial");

        // Glitch rejection and 34/35 threshold
        push_wr(13'd0, 8'hB2);
        push_wr(13'd1, 8'h4D);
        push_done(5'd2, 1'b0, 1'b0);
        send_byte_edge(8'hB2);
        send_byte_edge(8'h4D);
        drive(1'b0, 2600);
        wait_drain("frame_threshold");

        // Stuck-high line mid-frame: error, no done, re-arm only after a band
        push_wr(13'd0, 8'h77);
        push_stuck();
        send_byte(8'h77);
        drive(1'b1, 300);
        drive(1'b0, 100);
        send_byte(8'hEE);
        drive(1'b0, 2600);
        wait_drain("stuck_high");

        push_wr(13'd0, 8'h99);
        push_wr(13'd1, 8'h5A);
        push_done(5'd2, 1'b0, 1'b0);
        send_byte(8'h99);
        send_byte(8'h5A);
        drive(1'b0, 2600);
        wait_drain("after_stuck");

        // Reset mid-byte: outputs return to reset values after one edge
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        drive(1'b1, 10);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid_byte");
        strip_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 2700);
        wait_drain("after_mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
